// File: rtl/rle_pkg.sv
// Shared types and defaults for the run-length encoder control path
// (encoder control stage and the decoder-side run counter).
package rle_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int COUNT_W_DEF = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } rle_state_e;

    // Token at default widths, as consumed by the packer/serialiser.
    typedef struct packed {
        logic [DATA_W_DEF-1:0]  data;
        logic [COUNT_W_DEF-1:0] count;
    } rle_token_t;

    function automatic int rle_rmax(input int count_w);
        return (1 << count_w) - 1;
    endfunction

endpackage

// File: rtl/rle_run_ctrl_if.sv
// Input word stream and output token stream of the RLE control stage.
// slave = the encoder side, master = word source / token consumer side.
interface rle_run_ctrl_if
    import rle_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int COUNT_W = COUNT_W_DEF
);

    logic [DATA_W-1:0]  in_data;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  out_data;
    logic [COUNT_W-1:0] out_count;
    logic               out_valid;
    logic               out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_count, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_count, out_valid
    );

endinterface

// File: rtl/rle_run_counter.sv
// Run-length counter: load-to-1, saturating increment, all-ones flag.
// Shared between the encoder control stage and the decoder.
module rle_run_counter
    import rle_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load_i,
    input  logic               inc_i,
    output logic [COUNT_W-1:0] cnt_o,
    output logic               is_max_o
);

    logic [COUNT_W-1:0] cnt_q;
    logic [COUNT_W-1:0] cnt_d;

    assign is_max_o = &cnt_q;
    assign cnt_o    = cnt_q;

    // Load wins over increment; a saturated count never wraps to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = COUNT_W'(1);
        end else if (inc_i && !is_max_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rle_run_ctrl.sv
// RLE control stage: tracks the current run, emits (value, length) tokens
// through a single-entry valid/ready output register, with explicit flush.
module rle_run_ctrl
    import rle_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int COUNT_W = COUNT_W_DEF
) (
    input  logic           clock,
    input  logic           reset_n,
    rle_run_ctrl_if.slave  bus,
    input  logic           flush_i,
    output logic           inc_o,
    output logic           run_reset_o,
    output logic           busy_o
);

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [COUNT_W-1:0] count;
    } token_t;

    rle_state_e         state_q;
    logic [DATA_W-1:0]  cur_q;
    token_t             out_tok_q;
    logic               out_valid_q;
    logic               inc_q;
    logic               run_reset_q;

    logic [COUNT_W-1:0] cnt;
    logic               cnt_is_max;

    logic slot_free;
    logic in_ready;
    logic accept;
    logic can_extend;
    logic extend;
    logic close_run;
    logic flush_emit;
    logic load_tok;
    logic cnt_load;

    always_comb begin
        slot_free  = !out_valid_q || bus.out_ready;
        in_ready   = slot_free && !flush_i && (state_q != FLUSH);
        accept     = bus.in_valid && in_ready;
        can_extend = (bus.in_data == cur_q) && !cnt_is_max;
        extend     = accept && (state_q == RUN) && can_extend;
        close_run  = accept && (state_q == RUN) && !can_extend;
        // A held flush request and a fresh one in RUN both need a free slot.
        flush_emit = slot_free && (((state_q == RUN) && flush_i) || (state_q == FLUSH));
        load_tok   = close_run || flush_emit;
        cnt_load   = accept && !extend;
    end

    rle_run_counter #(
        .COUNT_W (COUNT_W)
    ) u_counter (
        .clock    (clock),
        .reset_n  (reset_n),
        .load_i   (cnt_load),
        .inc_i    (extend),
        .cnt_o    (cnt),
        .is_max_o (cnt_is_max)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= EMPTY;
            cur_q       <= '0;
            out_tok_q   <= '0;
            out_valid_q <= 1'b0;
            inc_q       <= 1'b0;
            run_reset_q <= 1'b0;
        end else begin
            inc_q       <= extend;
            run_reset_q <= close_run;

            // Reload in the drain cycle keeps the output register back-to-back.
            if (load_tok) begin
                out_valid_q     <= 1'b1;
                out_tok_q.data  <= cur_q;
                out_tok_q.count <= cnt;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (cnt_load) begin
                cur_q <= bus.in_data;
            end

            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (flush_i) begin
                        state_q <= slot_free ? EMPTY : FLUSH;
                    end
                end
                FLUSH: begin
                    if (slot_free) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_tok_q.data;
    assign bus.out_count = out_tok_q.count;
    assign inc_o         = inc_q;
    assign run_reset_o   = run_reset_q;
    assign busy_o        = (state_q != EMPTY);

endmodule

// File: tb/tb_rle_run_ctrl.sv
// Bench for rle_run_ctrl: COUNT_W=8 and COUNT_W=4 instances share stimulus,
// each checked every cycle against its own behavioural model.
module tb_rle_run_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        flush;
    logic        out_ready;

    always #5 clock = ~clock;

    rle_run_ctrl_if #(.DATA_W(32), .COUNT_W(8)) if8 ();
    rle_run_ctrl_if #(.DATA_W(32), .COUNT_W(4)) if4 ();

    assign if8.in_data   = in_data;
    assign if8.in_valid  = in_valid;
    assign if8.out_ready = out_ready;
    assign if4.in_data   = in_data;
    assign if4.in_valid  = in_valid;
    assign if4.out_ready = out_ready;

    logic inc8, rr8, busy8, inc4, rr4, busy4;

    rle_run_ctrl #(.DATA_W(32), .COUNT_W(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .bus(if8), .flush_i(flush),
        .inc_o(inc8), .run_reset_o(rr8), .busy_o(busy8)
    );

    rle_run_ctrl #(.DATA_W(32), .COUNT_W(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .bus(if4), .flush_i(flush),
        .inc_o(inc4), .run_reset_o(rr4), .busy_o(busy4)
    );

    logic        d_rdy [2];
    logic        d_ov  [2];
    logic        d_inc [2];
    logic        d_rr  [2];
    logic        d_busy[2];
    logic [31:0] d_od  [2];
    logic [31:0] d_oc  [2];

    assign d_rdy[0]  = if8.in_ready;   assign d_rdy[1]  = if4.in_ready;
    assign d_ov[0]   = if8.out_valid;  assign d_ov[1]   = if4.out_valid;
    assign d_inc[0]  = inc8;           assign d_inc[1]  = inc4;
    assign d_rr[0]   = rr8;            assign d_rr[1]   = rr4;
    assign d_busy[0] = busy8;          assign d_busy[1] = busy4;
    assign d_od[0]   = if8.out_data;   assign d_od[1]   = if4.out_data;
    assign d_oc[0]   = {24'd0, if8.out_count};
    assign d_oc[1]   = {28'd0, if4.out_count};

    int checks = 0;
    int errors = 0;

    // Behavioural model: held run, pending flush, one output slot.
    logic        m_has [2];
    logic        m_pend[2];
    logic        m_ov  [2];
    logic        m_inc [2];
    logic        m_rr  [2];
    logic [31:0] m_cur [2];
    logic [31:0] m_od  [2];
    int          m_cnt [2];
    int          m_oc  [2];

    logic [63:0] tlog0[$];
    logic [63:0] tlog1[$];
    int          inc_cnt[2];
    int          rr_cnt [2];

    function automatic int rmax(input int i);
        return (i == 0) ? 255 : 15;
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%h required=%h t=%0t", nm, i, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input int i, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%b required=%b t=%0t", nm, i, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        m_has[i] = 1'b0; m_pend[i] = 1'b0; m_ov[i] = 1'b0;
        m_inc[i] = 1'b0; m_rr[i] = 1'b0;
        m_cur[i] = '0;   m_od[i] = '0;
        m_cnt[i] = 0;    m_oc[i] = 0;
    endtask

    task automatic emit(input int i);
        m_ov[i] = 1'b1;
        m_od[i] = m_cur[i];
        m_oc[i] = m_cnt[i];
    endtask

    task automatic model_step(input int i);
        logic sf;
        logic acc;
        sf  = !m_ov[i] || out_ready;
        acc = in_valid && sf && !flush && !m_pend[i];
        m_inc[i] = 1'b0;
        m_rr[i]  = 1'b0;
        if (m_ov[i] && out_ready) m_ov[i] = 1'b0;
        if (m_pend[i] || (m_has[i] && flush)) begin
            if (sf) begin
                emit(i);
                m_has[i]  = 1'b0;
                m_pend[i] = 1'b0;
            end else begin
                m_pend[i] = 1'b1;
            end
        end else if (acc) begin
            if (!m_has[i]) begin
                m_has[i] = 1'b1;
                m_cur[i] = in_data;
                m_cnt[i] = 1;
            end else if (in_data == m_cur[i] && m_cnt[i] < rmax(i)) begin
                m_cnt[i] = m_cnt[i] + 1;
                m_inc[i] = 1'b1;
            end else begin
                emit(i);
                m_cur[i] = in_data;
                m_cnt[i] = 1;
                m_rr[i]  = 1'b1;
            end
        end
    endtask

    always @(negedge reset_n) begin
        for (int i = 0; i < 2; i++) model_reset(i);
    end

    always @(posedge clock) begin
        if (reset_n === 1'b1) begin
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    // Per-cycle comparison, well after inputs settle and before the next edge.
    always @(negedge clock) begin
        #2;
        for (int i = 0; i < 2; i++) begin
            chk1("in_ready", i, d_rdy[i], (!m_ov[i] || out_ready) && !flush && !m_pend[i]);
            chk1("out_valid", i, d_ov[i], m_ov[i]);
            if (m_ov[i]) begin
                chk("out_data", i, d_od[i], m_od[i]);
                chk("out_count", i, d_oc[i], m_oc[i]);
            end
            chk1("inc", i, d_inc[i], m_inc[i]);
            chk1("run_reset", i, d_rr[i], m_rr[i]);
            chk1("busy", i, d_busy[i], m_has[i] || m_pend[i]);
            if (reset_n === 1'b1) begin
                if (d_ov[i] && out_ready) begin
                    if (i == 0) tlog0.push_back({d_od[i], d_oc[i]});
                    else        tlog1.push_back({d_od[i], d_oc[i]});
                end
                if (d_inc[i]) inc_cnt[i]++;
                if (d_rr[i])  rr_cnt[i]++;
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic f, input logic r);
        @(negedge clock);
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = r;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 32'd0, 1'b0, 1'b1);
    endtask

    task automatic clear_logs();
        tlog0.delete();
        tlog1.delete();
        for (int i = 0; i < 2; i++) begin
            inc_cnt[i] = 0;
            rr_cnt[i]  = 0;
        end
    endtask

    task automatic exp_ntok(input string nm, input int i, input int n);
        chk(nm, i, (i == 0) ? tlog0.size() : tlog1.size(), n);
    endtask

    task automatic exp_tok(input string nm, input int i, input int k, input logic [31:0] d, input int c);
        logic [63:0] t;
        int sz;
        sz = (i == 0) ? tlog0.size() : tlog1.size();
        if (k >= sz) begin
            checks++;
            errors++;
            $display("FAIL %s dut%0d token %0d missing, only %0d logged", nm, i, k, sz);
        end else begin
            t = (i == 0) ? tlog0[k] : tlog1[k];
            chk({nm, "_data"}, i, t[63:32], d);
            chk({nm, "_count"}, i, t[31:0], c);
        end
    endtask

    localparam logic [31:0] VA = 32'hA5A5_0001;
    localparam logic [31:0] VB = 32'hA5A5_0002;
    localparam logic [31:0] VC = 32'hA5A5_0003;
    localparam logic [31:0] VD = 32'h0000_00D0;
    localparam logic [31:0] VE = 32'h0000_00E0;
    localparam logic [31:0] VF = 32'hFFFF_FFFF;

    initial begin
        logic [31:0] prev;
        logic [31:0] vals [3];
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) model_reset(i);
        clear_logs();

        repeat (3) @(negedge clock);
        #2;
        for (int i = 0; i < 2; i++) begin
            chk1("rst_out_valid", i, d_ov[i], 1'b0);
            chk1("rst_busy", i, d_busy[i], 1'b0);
            chk("rst_out_data", i, d_od[i], 32'd0);
            chk("rst_out_count", i, d_oc[i], 32'd0);
        end
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        reset_n = 1'b1;
        idle(2);

        // A,A,A,B then flush
        clear_logs();
        drive(1'b1, VA, 1'b0, 1'b1);
        drive(1'b1, VA, 1'b0, 1'b1);
        drive(1'b1, VA, 1'b0, 1'b1);
        drive(1'b1, VB, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 1'b1, 1'b1);
        idle(3);
        for (int i = 0; i < 2; i++) begin
            exp_ntok("t1_ntok", i, 2);
            exp_tok("t1_tok0", i, 0, VA, 3);
            exp_tok("t1_tok1", i, 1, VB, 1);
            chk("t1_inc_pulses", i, inc_cnt[i], 2);
            chk("t1_rr_pulses", i, rr_cnt[i], 1);
            chk1("t1_busy_end", i, d_busy[i], 1'b0);
        end

        // 17 equal words: saturation splits the run on the 4-bit counter
        clear_logs();
        for (int k = 0; k < 17; k++) drive(1'b1, VF, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 1'b1, 1'b1);
        idle(3);
        exp_ntok("t2_ntok", 0, 1);
        exp_tok("t2_tok0", 0, 0, VF, 17);
        chk("t2_inc_pulses", 0, inc_cnt[0], 16);
        exp_ntok("t2_ntok", 1, 2);
        exp_tok("t2_tok0", 1, 0, VF, 15);
        exp_tok("t2_tok1", 1, 1, VF, 2);
        chk("t2_inc_pulses", 1, inc_cnt[1], 15);
        chk("t2_rr_pulses", 1, rr_cnt[1], 1);

        // Backpressure: (A,2) stuck, B accepted, C blocked
        clear_logs();
        drive(1'b1, VA, 1'b0, 1'b0);
        drive(1'b1, VA, 1'b0, 1'b0);
        drive(1'b1, VB, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, VC, 1'b0, 1'b0);
            #2;
            for (int i = 0; i < 2; i++) chk1("t3_in_ready_blocked", i, d_rdy[i], 1'b0);
        end
        drive(1'b1, VC, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 1'b1, 1'b1);
        idle(3);
        for (int i = 0; i < 2; i++) begin
            exp_ntok("t3_ntok", i, 3);
            exp_tok("t3_tok0", i, 0, VA, 2);
            exp_tok("t3_tok1", i, 1, VB, 1);
            exp_tok("t3_tok2", i, 2, VC, 1);
        end

        // Flush under backpressure enters FLUSH and completes after release
        clear_logs();
        drive(1'b1, VA, 1'b0, 1'b0);
        drive(1'b1, VB, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        #2;
        for (int i = 0; i < 2; i++) begin
            chk1("t4_in_ready_flush", i, d_rdy[i], 1'b0);
            chk1("t4_busy_flush", i, d_busy[i], 1'b1);
        end
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        idle(3);
        for (int i = 0; i < 2; i++) begin
            exp_ntok("t4_ntok", i, 2);
            exp_tok("t4_tok0", i, 0, VA, 1);
            exp_tok("t4_tok1", i, 1, VB, 1);
            chk1("t4_busy_end", i, d_busy[i], 1'b0);
        end

        // flush and in_valid together: word refused, then accepted fresh
        clear_logs();
        drive(1'b1, VD, 1'b0, 1'b1);
        drive(1'b1, VD, 1'b1, 1'b1);
        #2;
        for (int i = 0; i < 2; i++) chk1("t5_in_ready_flush", i, d_rdy[i], 1'b0);
        drive(1'b1, VD, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 1'b1, 1'b1);
        idle(3);
        for (int i = 0; i < 2; i++) begin
            exp_ntok("t5_ntok", i, 2);
            exp_tok("t5_tok0", i, 0, VD, 1);
            exp_tok("t5_tok1", i, 1, VD, 1);
            chk("t5_inc_pulses", i, inc_cnt[i], 0);
        end

        // Asynchronous reset mid-run discards everything
        for (int k = 0; k < 5; k++) drive(1'b1, VE, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        @(posedge clock);
        #3;
        for (int i = 0; i < 2; i++) chk1("t6_busy_before", i, d_busy[i], 1'b1);
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk1("t6_busy_async", i, d_busy[i], 1'b0);
            chk1("t6_out_valid_async", i, d_ov[i], 1'b0);
            chk("t6_out_data_async", i, d_od[i], 32'd0);
            chk("t6_out_count_async", i, d_oc[i], 32'd0);
        end
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        reset_n = 1'b1;
        clear_logs();
        drive(1'b1, VF, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 1'b1, 1'b1);
        idle(3);
        for (int i = 0; i < 2; i++) begin
            exp_ntok("t6_ntok", i, 1);
            exp_tok("t6_tok0", i, 0, VF, 1);
            chk("t6_rr_pulses", i, rr_cnt[i], 0);
        end

        // Randomised traffic with long runs to reach saturation
        vals[0] = 32'h0000_0000;
        vals[1] = 32'hFFFF_FFFF;
        vals[2] = 32'h1234_5678;
        prev = vals[0];
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] d;
            d = ($urandom_range(0, 9) < 9) ? prev : vals[$urandom_range(0, 2)];
            prev = d;
            drive($urandom_range(0, 9) < 7, d, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) < 7);
        end
        drive(1'b0, 32'd0, 1'b1, 1'b1);
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
